// File: rtl/mem_read_seq.sv
// Tile read sequencer: issues one row address per cycle to bank 0 and skews it down the BRAM banks.
// Optional protocol-error detection is built when MEM_READ_SEQ_ERR_EN is defined.
module mem_read_seq #(
  parameter int D_W = 8,
  parameter int N   = 3,
  parameter int M   = 6,
  localparam int AW = $clog2((M*M)/N),
  localparam int TW = (M/N > 1) ? $clog2(M/N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [TW-1:0] tile_idx,
  input  logic          mode,
  input  logic          stall,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] rd_addr_bram [N-1:0],
  output logic [N-1:0]  rd_en_bram
);

  localparam int RW  = (M > 1) ? $clog2(M) : 1;
  localparam int DCW = (N > 1) ? $clog2(N) : 1;

  if (D_W < 1 || (M % N) != 0) begin : g_bad_cfg
    $error("mem_read_seq: D_W must be positive and M divisible by N");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   row_q;
  logic [TW-1:0]   tile_q;
  logic            mode_q;
  logic [DCW-1:0]  drain_q;
  logic [AW-1:0]   hold_q;
  logic [AW-1:0]   addr_c;
  logic            issue, last_issue, accept;

  assign accept     = (state_q == IDLE) && start;
  assign issue      = (state_q == RUN) && !stall;
  assign last_issue = issue && (row_q == RW'(M-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_issue) state_d = (N > 1) ? DRAIN : DONE;
      DRAIN:   if (drain_q == DCW'(N-2)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    if (state_q != IDLE) busy = 1'b1;
    if (state_q == DONE) done = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q   <= '0;
      tile_q  <= '0;
      mode_q  <= 1'b0;
      drain_q <= '0;
      hold_q  <= '0;
    end else begin
      if (accept) begin
        row_q  <= '0;
        tile_q <= tile_idx;
        mode_q <= mode;
      end else if (issue) begin
        row_q <= row_q + RW'(1);
      end
      if (state_q != DRAIN) drain_q <= '0;
      else                  drain_q <= drain_q + DCW'(1);
      if (issue) hold_q <= addr_c;
    end
  end

  // Bank-0 address is live while issuing and otherwise parks on the last issued value
  assign addr_c = AW'(mode_q ? (32'(row_q) * 32'(M/N) + 32'(tile_q))
                             : (32'(tile_q) * 32'(M) + 32'(row_q)));
  assign rd_en_bram[0]   = issue;
  assign rd_addr_bram[0] = issue ? addr_c : hold_q;

  // Skew chain runs every cycle so stall bubbles ripple down the banks
  for (genvar x = 1; x < N; x++) begin : g_skew
    logic [AW-1:0] addr_q;
    logic          en_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        addr_q <= '0;
        en_q   <= 1'b0;
      end else begin
        addr_q <= rd_addr_bram[x-1];
        en_q   <= rd_en_bram[x-1];
      end
    end
    assign rd_addr_bram[x] = addr_q;
    assign rd_en_bram[x]   = en_q;
  end

`ifdef MEM_READ_SEQ_ERR_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              err_q <= 1'b0;
    else if (accept)         err_q <= 1'b0;
    else if (start && busy)  err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_read_seq.sv
// Directed bench for mem_read_seq with N=3, M=6: tile reads, stall bubble, mid-run reset, error flag.
module tb_mem_read_seq;
  localparam int N  = 3;
  localparam int M  = 6;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [0:0]    tile_idx;
  logic          mode;
  logic          stall;
  logic          busy, done, err;
  logic [AW-1:0] rd_addr_bram [N-1:0];
  logic [N-1:0]  rd_en_bram;

  int total = 0;
  int bad   = 0;

`ifdef MEM_READ_SEQ_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  // stall-in-cycle-3 run, tile 1 mode 0: bank-0 enable and address per cycle 0..12
  int st_en  [13] = '{0, 1, 1, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0};
  int st_adr [13] = '{0, 6, 7, 7, 8, 9, 10, 11, 11, 11, 11, 11, 11};

  mem_read_seq #(.D_W(8), .N(N), .M(M)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .tile_idx     (tile_idx),
    .mode         (mode),
    .stall        (stall),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .rd_addr_bram (rd_addr_bram),
    .rd_en_bram   (rd_en_bram)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic t, input logic m);
    @(negedge clk);
    start = 1'b1; tile_idx = t; mode = m;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"}, 32'(rd_en_bram), 32'd0);
    for (int b = 0; b < N; b++) chk({tag, "_addr"}, 32'(rd_addr_bram[b]), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"},  32'(err),  32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; tile_idx = '0; mode = 1'b0; stall = 1'b0;
    #2;
    chk_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;
    next_cycle();

    // Tile 0, mode 0: banks skewed by one cycle each, done in cycle 9
    launch(1'b0, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      for (int b = 0; b < N; b++) begin
        chk("t1_en", 32'(rd_en_bram[b]), (c - b >= 1 && c - b <= 6) ? 32'd1 : 32'd0);
        if (c - b >= 1 && c - b <= 6) chk("t1_addr", 32'(rd_addr_bram[b]), 32'(c - b - 1));
      end
      chk("t1_busy", 32'(busy), (c <= 9) ? 32'd1 : 32'd0);
      chk("t1_done", 32'(done), (c == 9) ? 32'd1 : 32'd0);
      next_cycle();
    end

    // Tile 1, mode 1: bank-0 addresses 1,3,5,...; start in DONE cycle is ignored
    launch(1'b1, 1'b1);
    for (int c = 1; c <= 11; c++) begin
      start = (c == 9);
      @(negedge clk);
      chk("t2_en0", 32'(rd_en_bram[0]), (c <= 6) ? 32'd1 : 32'd0);
      if (c <= 6) chk("t2_addr0", 32'(rd_addr_bram[0]), 32'(2 * c - 1));
      chk("t2_done", 32'(done), (c == 9) ? 32'd1 : 32'd0);
      chk("t2_busy", 32'(busy), (c <= 9) ? 32'd1 : 32'd0);
      next_cycle();
    end
    start = 1'b0;

    // Tile 1, mode 0 with stall in cycle 3: bubble walks down the banks, done in cycle 10
    launch(1'b1, 1'b0);
    for (int c = 1; c <= 11; c++) begin
      stall = (c == 3);
      @(negedge clk);
      for (int b = 0; b < N; b++) begin
        if (c - b >= 0) chk("t3_en", 32'(rd_en_bram[b]), 32'(st_en[c - b]));
        if (c - b >= 1) chk("t3_addr", 32'(rd_addr_bram[b]), 32'(st_adr[c - b]));
      end
      chk("t3_done", 32'(done), (c == 10) ? 32'd1 : 32'd0);
      chk("t3_busy", 32'(busy), (c <= 10) ? 32'd1 : 32'd0);
      next_cycle();
    end
    stall = 1'b0;

    // Reset in cycle 4 clears everything immediately; restart reads from row 0
    launch(1'b0, 1'b0);
    next_cycle(); next_cycle(); next_cycle();
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    next_cycle();
    chk_all_zero("midrst_hold");
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post_rst_done", 32'(done), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_en",   32'(rd_en_bram), 32'd0);
      next_cycle();
    end
    launch(1'b0, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      chk("rst_re_en0", 32'(rd_en_bram[0]), (c <= 6) ? 32'd1 : 32'd0);
      if (c <= 6) chk("rst_re_addr0", 32'(rd_addr_bram[0]), 32'(c - 1));
      chk("rst_re_done", 32'(done), (c == 9) ? 32'd1 : 32'd0);
      next_cycle();
    end

    // start re-asserted in cycle 3: err only when detection is built; sequence unaffected
    launch(1'b0, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      start = (c == 3);
      @(negedge clk);
      chk("t5_en0", 32'(rd_en_bram[0]), (c <= 6) ? 32'd1 : 32'd0);
      if (c <= 6) chk("t5_addr0", 32'(rd_addr_bram[0]), 32'(c - 1));
      chk("t5_en2", 32'(rd_en_bram[2]), (c >= 3 && c <= 8) ? 32'd1 : 32'd0);
      chk("t5_done", 32'(done), (c == 9) ? 32'd1 : 32'd0);
      chk("t5_err", 32'(err), (ERR_ON && c >= 4) ? 32'd1 : 32'd0);
      next_cycle();
    end
    start = 1'b0;
    launch(1'b1, 1'b0);
    @(negedge clk);
    chk("t5_err_clr", 32'(err), 32'd0);
    chk("t5_relaunch_addr0", 32'(rd_addr_bram[0]), 32'd6);
    next_cycle();
    for (int c = 2; c <= 10; c++) next_cycle();
    @(negedge clk);
    chk("final_idle_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_read_seq.md
MEM_READ_SEQ -- requirements
Module: mem_read_seq

Interface
REQ-001 Parameter D_W, default 8: operand data width, carried for consistency with the array; no logic depends on it.
REQ-002 Parameter N, default 3: number of BRAM banks and the systolic array dimension.
REQ-003 Parameter M, default 6: matrix dimension; M divisible by N; AW = $clog2((M*M)/N), TW = $clog2(M/N).
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 start  in  1  request to begin a tile read; sampled only in IDLE.
REQ-007 tile_idx  in  TW  column-tile index, latched when start is accepted.
REQ-008 mode  in  1  addressing mode, latched with start: 0 = tile-major, 1 = row-interleaved.
REQ-009 stall  in  1  downstream back-pressure; suppresses the current issue cycle.
REQ-010 busy  out  1  high in RUN, DRAIN and DONE.
REQ-011 done  out  1  one-cycle pulse when the last bank's final read has issued.
REQ-012 err  out  1  sticky protocol-error flag.
REQ-013 rd_addr_bram  out  AW x N (unpacked [N-1:0])  per-bank read address.
REQ-014 rd_en_bram  out  N  per-bank read enable.

Function
REQ-015 The FSM has four states: IDLE, RUN, DRAIN and DONE.
- IDLE->RUN: start=1.
- RUN->DRAIN: after the issue with row=M-1.
- DRAIN->DONE: after N-1 cycles.
- DONE->IDLE: unconditionally, after one cycle.
REQ-016 Row counter: reset to 0 on start acceptance; increments by 1 on each RUN cycle with stall=0; holds while stall=1.
REQ-017 Bank-0 issue (rd_en_bram[0]=1) occurs in RUN cycles with stall=0; rd_en_bram[0]=0 in all other cycles.
REQ-018 Bank-0 address is computed combinationally from the counter and the latched fields, not registered:
- mode 0: tile_idx*M + row.
- mode 1: row*(M/N) + tile_idx.
- Computed in 32 bits, truncated to AW; in-range for legal tile_idx < M/N.
REQ-019 rd_addr_bram[0] holds its last value whenever rd_en_bram[0]=0.
REQ-020 Bank x (x = 1..N-1) receives bank x-1's address and enable delayed by exactly one register stage, giving bank x a total skew of x cycles.
REQ-021 The skew chain shifts every cycle regardless of stall and state, so stall bubbles propagate down the banks.
REQ-022 DRAIN lasts N-1 cycles, so the final bank-(N-1) enable falls in the last DRAIN cycle. When N=1, DRAIN is skipped and RUN goes directly to DONE.
REQ-023 done=1 only in the DONE state.
REQ-024 start is ignored while busy=1; a start asserted in the DONE cycle is ignored.
REQ-025 A stall in the first RUN cycle delays row 0's issue; total RUN length is M plus the number of stall cycles.

Reset
REQ-026 While rst_n=0, the following are cleared immediately without waiting for a clock edge:
- FSM to IDLE; row counter, latched tile_idx and latched mode to 0.
- All skew registers to 0, so every rd_addr_bram and rd_en_bram output is 0.
- busy, done and err to 0.
REQ-027 When reset is asserted mid-operation, the tile is abandoned with no done pulse; the block resumes in IDLE.

Configuration
REQ-028 Macro MEM_READ_SEQ_ERR_EN controls protocol-error detection.
- Defined: err sets when start=1 while busy=1 and clears on the next accepted start.
- Undefined: err is tied to 0 and no detection logic is built.

Verification (N=3, M=6; cycle 1 = first cycle after the edge accepting start)
REQ-029 start, tile_idx=0, mode=0 -> expected response:
- bank0 en with addr 0,1,2,3,4,5 in cycles 1-6.
- bank1 same sequence in cycles 2-7; bank2 in cycles 3-8.
- done=1 in cycle 9 only; busy=1 in cycles 1-9.
REQ-030 start, tile_idx=1, mode=1 -> bank0 addr 1,3,5,7,9,11 in cycles 1-6.
REQ-031 tile_idx=1, mode=0, stall=1 in cycle 3 -> expected response:
- bank0: addr 6,7 in cycles 1-2; en=0 in cycle 3; addr 8-11 in cycles 4-7.
- The bubble appears at bank2 in cycle 5; done in cycle 10.
REQ-032 rst_n=0 in cycle 4 -> all outputs 0 immediately; no done; a new start after release reads from row 0.
REQ-033 start re-asserted in cycle 3 with MEM_READ_SEQ_ERR_EN defined -> err=1 from cycle 4 and the sequence is unaffected; without the macro, err stays 0.
